// File: rtl/pipeline_pkg.sv
// Shared RV32I pipeline types and constants.
// Fetch FSM encoding and the IF/ID register layout used by the fetch stage.
package pipeline_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic            valid;
    } ifid_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter with hold / +4 / redirect next-PC selection; updates on the next edge.
// Redirect wins over advance; redirect targets are forced to word alignment.
module fetch_pc_gen
    import pipeline_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            advance,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc
);

    logic [XLEN-1:0] pc_next;

    always_comb begin
        pc_next = pc;
        if (redirect) begin
            pc_next = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (advance) begin
            pc_next = pc + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem request, IF/ID load 2 edges after a zero-wait request.
// pc_write=0 freezes PC and IF/ID, parking a returned word in hold_buf; redirect overrides the stall.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_write,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_gnt,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    output logic [31:0] IF_instrout,
    output logic [31:0] IF_pcout,
    output logic        IF_valid,
    output logic        fetch_busy
);
    import pipeline_pkg::*;

    fetch_state_t    state;
    logic            kill;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] hold_buf;
    logic [XLEN-1:0] pc_redir;
    logic            deliver;
    logic            advance;
    ifid_t           ifid;

    assign pc_redir   = {redirect_pc[XLEN-1:2], 2'b00};
    assign deliver    = ((state == WAIT) && im_rvalid && !kill) || (state == HOLD);
    assign advance    = deliver && pc_write && !redirect;
    assign fetch_busy = !deliver;
    assign im_req     = (state == REQ);
    assign im_addr    = pc;

    assign IF_instrout = ifid.instr;
    assign IF_pcout    = ifid.pc;
    assign IF_valid    = ifid.valid;

    fetch_pc_gen #(
        .RESET_PC(RESET_PC)
    ) u_pc_gen (
        .clk         (clk),
        .rst         (rst),
        .advance     (advance),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (pc)
    );

    // A request already granted cannot be withdrawn, so a redirect marks its response for discard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            kill     <= 1'b0;
            hold_buf <= '0;
        end else if (redirect) begin
            case (state)
                REQ: begin
                    if (im_gnt) begin
                        state <= WAIT;
                        kill  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (im_rvalid) begin
                        state <= REQ;
                        kill  <= 1'b0;
                    end else begin
                        kill  <= 1'b1;
                    end
                end
                default: state <= REQ;
            endcase
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (im_gnt) state <= WAIT;
                end
                WAIT: begin
                    if (im_rvalid) begin
                        if (kill) begin
                            kill  <= 1'b0;
                            state <= REQ;
                        end else if (pc_write) begin
                            state <= REQ;
                        end else begin
                            hold_buf <= im_rdata;
                            state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (pc_write) state <= REQ;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid.instr <= NOP_INSTR;
            ifid.pc    <= '0;
            ifid.valid <= 1'b0;
        end else if (redirect) begin
            ifid.instr <= NOP_INSTR;
            ifid.pc    <= pc_redir;
            ifid.valid <= 1'b0;
        end else if (pc_write) begin
            ifid.instr <= deliver ? ((state == HOLD) ? hold_buf : im_rdata) : NOP_INSTR;
            ifid.pc    <= pc;
            ifid.valid <= deliver;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: behavioural imem with configurable grant/latency and
// scoreboards for request addresses and IF/ID contents.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_write;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_gnt;
    logic        im_rvalid;
    logic [31:0] im_rdata;
    logic [31:0] IF_instrout;
    logic [31:0] IF_pcout;
    logic        IF_valid;
    logic        fetch_busy;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .pc_write    (pc_write),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .im_req      (im_req),
        .im_addr     (im_addr),
        .im_gnt      (im_gnt),
        .im_rvalid   (im_rvalid),
        .im_rdata    (im_rdata),
        .IF_instrout (IF_instrout),
        .IF_pcout    (IF_pcout),
        .IF_valid    (IF_valid),
        .fetch_busy  (fetch_busy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc, gnt_cnt, n_deliv, squash, cnt, rv_delay, c0;
    bit          gnt_en, pend, prev_v;
    logic [31:0] paddr, prev_pc;
    logic [31:0] addr_q[$];
    logic [63:0] exp_q[$];

    function automatic logic [31:0] inst_of(input logic [31:0] addr);
        return {addr[17:2], 16'h0593} ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: sample IF/ID at the falling edge, then drive imem for the next rising edge.
    task automatic tick();
        logic [63:0] e;
        @(negedge clk);
        cyc++;
        if (IF_valid && (!prev_v || IF_pcout != prev_pc)) begin
            n_deliv++;
            check("sb_depth", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("if_pc", IF_pcout, e[63:32]);
                check("if_instr", IF_instrout, e[31:0]);
            end
        end
        prev_v  = IF_valid;
        prev_pc = IF_pcout;
        im_rvalid = 1'b0;
        im_gnt    = 1'b0;
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                pend      = 1'b0;
                im_rvalid = 1'b1;
                im_rdata  = inst_of(paddr);
                if (squash > 0) squash--;
                else exp_q.push_back({paddr, inst_of(paddr)});
            end
        end
        if (im_req && gnt_en && !pend) begin
            im_gnt = 1'b1;
            pend   = 1'b1;
            cnt    = rv_delay;
            paddr  = im_addr;
            gnt_cnt++;
            check("req_expected", 32'(addr_q.size() != 0), 32'd1);
            if (addr_q.size() != 0) check("im_addr", im_addr, addr_q.pop_front());
        end
    endtask

    task automatic wait_grants(input int n);
        for (int k = 0; k < 60 && gnt_cnt < n; k++) tick();
        check("grants_reached", gnt_cnt, n);
    endtask

    task automatic wait_deliv(input int n);
        for (int k = 0; k < 60 && n_deliv < n; k++) tick();
        check("deliv_reached", n_deliv, n);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pc_write = 1'b1; redirect = 1'b0; redirect_pc = '0;
        im_gnt = 1'b0; im_rvalid = 1'b0; im_rdata = '0;
        gnt_en = 1'b1; rv_delay = 1; pend = 1'b0; cnt = 0; squash = 0;
        gnt_cnt = 0; n_deliv = 0; prev_v = 1'b0; prev_pc = '0; cyc = 0;
        addr_q.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Zero-wait memory streaming
        do_reset();
        check("rst_im_req", 32'(im_req), 32'd0);
        check("rst_im_addr", im_addr, 32'd0);
        check("rst_instr", IF_instrout, NOP);
        check("rst_pc", IF_pcout, 32'd0);
        check("rst_valid", 32'(IF_valid), 32'd0);
        check("rst_busy", 32'(fetch_busy), 32'd1);
        for (int a = 0; a <= 16; a += 4) addr_q.push_back(32'(a));
        c0 = cyc;
        wait_deliv(1);
        check("first_latency", 32'(cyc - c0), 32'd3);
        c0 = cyc;
        wait_deliv(2);
        check("throughput", 32'(cyc - c0), 32'd2);
        wait_deliv(4);
        check("p1_addr_drained", 32'(addr_q.size()), 32'd0);

        // Decode stall while the response lands
        do_reset();
        addr_q.push_back(32'h0); addr_q.push_back(32'h4); addr_q.push_back(32'h8);
        wait_grants(2);
        pc_write = 1'b0;
        tick();
        tick();
        check("hold_busy", 32'(fetch_busy), 32'd0);
        check("hold_pc", IF_pcout, 32'h0);
        check("hold_valid", 32'(IF_valid), 32'd1);
        check("hold_req", 32'(im_req), 32'd0);
        tick();
        check("hold_instr", IF_instrout, inst_of(32'h0));
        check("hold_busy2", 32'(fetch_busy), 32'd0);
        pc_write = 1'b1;
        tick();
        check("release_pc", IF_pcout, 32'h4);
        wait_grants(3);
        check("p2_addr_drained", 32'(addr_q.size()), 32'd0);

        // Redirect while waiting, stale response two cycles later
        do_reset();
        rv_delay = 3;
        addr_q.push_back(32'h0); addr_q.push_back(32'h100); addr_q.push_back(32'h104);
        wait_grants(1);
        tick();
        redirect = 1'b1; redirect_pc = 32'h103; squash = 1;
        tick();
        redirect = 1'b0;
        check("redir_valid", 32'(IF_valid), 32'd0);
        check("redir_instr", IF_instrout, NOP);
        check("redir_req", 32'(im_req), 32'd0);
        wait_deliv(1);
        wait_grants(3);
        check("p3_addr_drained", 32'(addr_q.size()), 32'd0);

        // Redirect in the same cycle as rvalid
        do_reset();
        addr_q.push_back(32'h0); addr_q.push_back(32'h200); addr_q.push_back(32'h204);
        wait_grants(1);
        squash = 1;
        tick();
        redirect = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        check("samecyc_addr", im_addr, 32'h200);
        check("samecyc_req", 32'(im_req), 32'd1);
        check("samecyc_valid", 32'(IF_valid), 32'd0);
        wait_deliv(1);
        wait_grants(3);
        check("p4_addr_drained", 32'(addr_q.size()), 32'd0);

        // Grant withheld for four cycles
        do_reset();
        gnt_en = 1'b0;
        addr_q.push_back(32'h0); addr_q.push_back(32'h4);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("nognt_req", 32'(im_req), 32'd1);
            check("nognt_addr", im_addr, 32'h0);
            check("nognt_busy", 32'(fetch_busy), 32'd1);
            check("nognt_valid", 32'(IF_valid), 32'd0);
            check("nognt_instr", IF_instrout, NOP);
        end
        gnt_en = 1'b1;
        wait_deliv(1);
        wait_grants(2);
        check("p5_addr_drained", 32'(addr_q.size()), 32'd0);

        // PC wrap, then reset in the middle of a wait
        do_reset();
        gnt_en = 1'b0;
        addr_q.push_back(32'hFFFF_FFFC); addr_q.push_back(32'h0);
        tick();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        check("wrap_target", im_addr, 32'hFFFF_FFFC);
        gnt_en = 1'b1;
        wait_grants(1);
        rv_delay = 3;
        wait_deliv(1);
        wait_grants(2);
        pc_write = 1'b0;
        tick();
        check("pre_rst_valid", 32'(IF_valid), 32'd1);
        check("pre_rst_pc", IF_pcout, 32'hFFFF_FFFC);
        rst = 1'b1;
        #1;
        check("midrst_req", 32'(im_req), 32'd0);
        check("midrst_addr", im_addr, 32'h0);
        check("midrst_instr", IF_instrout, NOP);
        check("midrst_pc", IF_pcout, 32'h0);
        check("midrst_valid", 32'(IF_valid), 32'd0);
        check("midrst_busy", 32'(fetch_busy), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
